// File: rtl/csr_access_unit_if.sv
// Bundles the decode, writeback, CSR-file and trap signals of the CSR access unit.
// Valid/ready: a transfer happens on a rising clock edge where valid and ready are both 1; once valid rises, the producer holds it and its payload unchanged until that edge.
interface csr_access_unit_if #(
    parameter int XLEN = 32
);
    // decode -> unit
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_kind;
    logic [2:0]      in_funct3;
    logic [11:0]     in_csr_addr;
    logic [4:0]      in_rs1_idx;
    logic [XLEN-1:0] in_rs1_val;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_a5;

    // unit <-> CSR register file
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_wen;
    logic [XLEN-1:0] csr_rdata;
    logic            o_ecall;
    logic            o_mret;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_a5;
    logic [XLEN-1:0] i_mtvec;
    logic [XLEN-1:0] i_mepc;

    // unit -> writeback
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic            out_rd_wen;
    logic [XLEN-1:0] out_rd_data;
    logic            out_redirect;
    logic [XLEN-1:0] out_redirect_pc;
    logic            out_illegal;

    modport master (
        input  in_valid, in_kind, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val,
               in_rd, in_pc, in_a5, csr_rdata, i_mtvec, i_mepc, out_ready,
        output in_ready, csr_addr, csr_wdata, csr_wen, o_ecall, o_mret, o_pc, o_a5,
               out_valid, out_rd, out_rd_wen, out_rd_data, out_redirect,
               out_redirect_pc, out_illegal
    );

    modport slave (
        output in_valid, in_kind, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val,
               in_rd, in_pc, in_a5, csr_rdata, i_mtvec, i_mepc, out_ready,
        input  in_ready, csr_addr, csr_wdata, csr_wen, o_ecall, o_mret, o_pc, o_a5,
               out_valid, out_rd, out_rd_wen, out_rd_data, out_redirect,
               out_redirect_pc, out_illegal
    );
endinterface

// File: rtl/csr_access_unit.sv
// Execute-stage initiator for machine-mode CSR accesses and ecall/mret traps.
// One SYSTEM instruction in flight: IDLE -> READ -> WRITE -> RESP, or IDLE -> TRAP -> RESP.
module csr_access_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TGT = '0
) (
    input  logic               clock,
    input  logic               rst_n,
    csr_access_unit_if.master  bus,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_TRAP  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] KIND_CSR   = 2'd0;
    localparam logic [1:0] KIND_ECALL = 2'd1;
    localparam logic [1:0] KIND_MRET  = 2'd2;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    state_t state_q;
    state_t state_d;

    logic [1:0]      kind_q;
    logic [2:0]      funct3_q;
    logic [11:0]     addr_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] a5_q;
    logic [XLEN-1:0] old_q;
    logic            illegal_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            accept;
    logic            in_bad;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] new_val;
    logic            write_req;
    logic            addr_legal;
    logic            addr_ro;
    logic            write_fault;

    assign accept    = (state_q == S_IDLE) && bus.in_valid;
    assign dbg_state = state_q;

    // Reserved kind and the two unused funct3 encodings are rejected without touching the CSR file.
    assign in_bad = (bus.in_kind == 2'd3) ||
                    ((bus.in_kind == KIND_CSR) &&
                     ((bus.in_funct3 == 3'd0) || (bus.in_funct3 == 3'd4)));

    assign src = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;

    always_comb begin
        new_val = src;
        case (funct3_q[1:0])
            OP_RW:   new_val = src;
            OP_RS:   new_val = old_q | src;
            default: new_val = old_q & ~src;
        endcase
    end

    // Set/clear forms with rs1 (or zimm) index 0 only read, so they may target read-only CSRs.
    assign write_req = (funct3_q[1:0] == OP_RW) || (rs1_idx_q != 5'd0);

    always_comb begin
        addr_legal = 1'b0;
        addr_ro    = 1'b0;
        case (addr_q)
            12'h300, 12'h305, 12'h341, 12'h342: addr_legal = 1'b1;
            12'hF11, 12'hF12: begin
                addr_legal = 1'b1;
                addr_ro    = 1'b1;
            end
            default: begin
                addr_legal = 1'b0;
                addr_ro    = 1'b0;
            end
        endcase
    end

    assign write_fault = !addr_legal || (write_req && addr_ro);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        bus.in_ready        = 1'b0;
        bus.csr_addr        = '0;
        bus.csr_wdata       = '0;
        bus.csr_wen         = 1'b0;
        bus.o_ecall         = 1'b0;
        bus.o_mret          = 1'b0;
        bus.o_pc            = '0;
        bus.o_a5            = '0;
        bus.out_valid       = 1'b0;
        bus.out_rd_wen      = 1'b0;
        bus.out_redirect    = 1'b0;
        bus.out_illegal     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (in_bad) begin
                        state_d = S_RESP;
                    end else if (bus.in_kind == KIND_CSR) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_TRAP;
                    end
                end
            end
            S_READ: begin
                bus.csr_addr = addr_q;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                bus.csr_addr  = addr_q;
                bus.csr_wdata = new_val;
                bus.csr_wen   = write_req && !write_fault;
                state_d       = S_RESP;
            end
            S_TRAP: begin
                bus.o_ecall = (kind_q == KIND_ECALL);
                bus.o_mret  = (kind_q == KIND_MRET);
                if (kind_q == KIND_ECALL) begin
                    bus.o_pc = pc_q;
                    bus.o_a5 = a5_q;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                bus.out_valid    = 1'b1;
                bus.out_illegal  = illegal_q;
                bus.out_redirect = !illegal_q && (kind_q != KIND_CSR);
                bus.out_rd_wen   = !illegal_q && (kind_q == KIND_CSR) && (rd_q != 5'd0);
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response payload comes straight from registers, so it stays put while writeback stalls.
    assign bus.out_rd          = rd_q;
    assign bus.out_rd_data     = old_q;
    assign bus.out_redirect_pc = redirect_pc_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            kind_q        <= '0;
            funct3_q      <= '0;
            addr_q        <= '0;
            rs1_idx_q     <= '0;
            rs1_val_q     <= '0;
            rd_q          <= '0;
            pc_q          <= '0;
            a5_q          <= '0;
            old_q         <= '0;
            illegal_q     <= 1'b0;
            redirect_pc_q <= RESET_PC_TGT;
        end else begin
            if (accept) begin
                kind_q    <= bus.in_kind;
                funct3_q  <= bus.in_funct3;
                addr_q    <= bus.in_csr_addr;
                rs1_idx_q <= bus.in_rs1_idx;
                rs1_val_q <= bus.in_rs1_val;
                rd_q      <= bus.in_rd;
                pc_q      <= bus.in_pc;
                a5_q      <= bus.in_a5;
                old_q     <= '0;
                illegal_q <= in_bad;
            end
            if (state_q == S_READ) begin
                old_q <= bus.csr_rdata;
            end
            if (state_q == S_WRITE) begin
                illegal_q <= write_fault;
            end
            // i_mtvec / i_mepc are only guaranteed during the pulse cycle.
            if (state_q == S_TRAP) begin
                redirect_pc_q <= (kind_q == KIND_ECALL) ? bus.i_mtvec : bus.i_mepc;
            end
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed cases plus random SYSTEM instructions checked
// against a CSR-level reference model and a scoreboard of expected CSR writes.
module tb_csr_access_unit;

    localparam int              XLEN    = 32;
    localparam logic [31:0]     RST_TGT = 32'h0000_1000;

    logic       clock;
    logic       rst_n;
    logic [2:0] dbg_state;

    csr_access_unit_if #(.XLEN(XLEN)) bus ();

    csr_access_unit #(.XLEN(XLEN), .RESET_PC_TGT(RST_TGT)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- counters / check ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- CSR register file seen by the DUT ----------------
    logic [31:0] f_mstatus = 32'h0000_1800;
    logic [31:0] f_mtvec   = 32'h0;
    logic [31:0] f_mepc    = 32'h0;
    logic [31:0] f_mcause  = 32'h0;

    always_comb begin
        case (bus.csr_addr)
            12'h300: bus.csr_rdata = f_mstatus;
            12'h305: bus.csr_rdata = f_mtvec;
            12'h341: bus.csr_rdata = f_mepc;
            12'h342: bus.csr_rdata = f_mcause;
            12'hF11: bus.csr_rdata = 32'h0000_0612;
            12'hF12: bus.csr_rdata = 32'h2306_0124;
            default: bus.csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clock) begin
        if (rst_n && bus.csr_wen) begin
            case (bus.csr_addr)
                12'h300: f_mstatus <= bus.csr_wdata;
                12'h305: f_mtvec   <= bus.csr_wdata;
                12'h341: f_mepc    <= bus.csr_wdata;
                12'h342: f_mcause  <= bus.csr_wdata;
                default: ;
            endcase
        end
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_csr [int];
    logic [43:0] exp_q [$];
    int          ecall_seen;
    int          mret_seen;
    logic [31:0] exp_pc;
    logic [31:0] exp_a5;

    // ---------------- monitor: writes and pulses ----------------
    always @(negedge clock) begin
        if (bus.csr_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wen", {bus.csr_addr, bus.csr_wdata}, 44'h0);
            end else begin
                check("csr_write", {bus.csr_addr, bus.csr_wdata}, exp_q.pop_front());
            end
        end
        if (bus.o_ecall) begin
            ecall_seen++;
            check("o_pc", bus.o_pc, exp_pc);
            check("o_a5", bus.o_a5, exp_a5);
        end
        if (bus.o_mret) mret_seen++;
    end

    function automatic logic [71:0] resp_snap();
        return {bus.out_rd, bus.out_rd_wen, bus.out_rd_data, bus.out_redirect,
                bus.out_redirect_pc, bus.out_illegal};
    endfunction

    // ---------------- driver + reference for one instruction ----------------
    task automatic run_instr(input logic [1:0] kind, input logic [2:0] f3,
                             input logic [11:0] addr, input logic [4:0] idx,
                             input logic [31:0] val, input logic [4:0] rd,
                             input logic [31:0] pc, input logic [31:0] a5,
                             input logic [31:0] mtvec, input logic [31:0] mepc,
                             input int hold);
        logic        e_ill, e_rdwen, e_redir, wreq, legal;
        logic [31:0] old, src, nv, e_tgt;
        int          e_lat, lat;
        logic [71:0] snap;

        e_ill = 1'b0; e_rdwen = 1'b0; e_redir = 1'b0; old = 32'h0; e_tgt = 32'h0;
        if (kind == 2'd3 || (kind == 2'd0 && (f3 == 3'd0 || f3 == 3'd4))) begin
            e_ill = 1'b1; e_lat = 1;
        end else if (kind == 2'd0) begin
            e_lat = 3;
            legal = ref_csr.exists(int'(addr));
            old   = legal ? ref_csr[int'(addr)] : 32'h0;
            src   = f3[2] ? 32'(idx) : val;
            wreq  = (f3[1:0] == 2'd1) || (idx != 0);
            e_ill = !legal || (wreq && (addr == 12'hF11 || addr == 12'hF12));
            if (!e_ill && wreq) begin
                if (f3[1:0] == 2'd1)      nv = src;
                else if (f3[1:0] == 2'd2) nv = old | src;
                else                      nv = old & ~src;
                exp_q.push_back({addr, nv});
                ref_csr[int'(addr)] = nv;
            end
            e_rdwen = !e_ill && (rd != 0);
        end else begin
            e_lat = 2; e_redir = 1'b1;
            e_tgt = (kind == 2'd1) ? mtvec : mepc;
        end

        ecall_seen = 0; mret_seen = 0; exp_pc = pc; exp_a5 = a5;
        @(negedge clock);
        bus.in_kind = kind; bus.in_funct3 = f3; bus.in_csr_addr = addr;
        bus.in_rs1_idx = idx; bus.in_rs1_val = val; bus.in_rd = rd;
        bus.in_pc = pc; bus.in_a5 = a5; bus.i_mtvec = mtvec; bus.i_mepc = mepc;
        bus.in_valid = 1'b1;
        check("in_ready_idle", bus.in_ready, 1'b1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        check("latency", lat, e_lat);
        check("out_valid", bus.out_valid, 1'b1);
        check("in_ready_busy", bus.in_ready, 1'b0);
        check("out_illegal", bus.out_illegal, e_ill);
        check("out_redirect", bus.out_redirect, e_redir);
        check("out_rd_wen", bus.out_rd_wen, e_rdwen);
        check("out_rd", bus.out_rd, rd);
        if (kind == 2'd0 && !e_ill) check("out_rd_data", bus.out_rd_data, old);
        if (e_redir) check("redirect_pc", bus.out_redirect_pc, e_tgt);
        snap = resp_snap();
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            check("resp_stable", resp_snap(), snap);
            check("stall_valid", bus.out_valid, 1'b1);
            check("stall_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check("valid_drop", bus.out_valid, 1'b0);
        check("back_idle", bus.in_ready, 1'b1);
        check("missing_wen", exp_q.size(), 0);
        check("ecall_pulses", ecall_seen, (kind == 2'd1) ? 1 : 0);
        check("mret_pulses", mret_seen, (kind == 2'd2) ? 1 : 0);
    endtask

    // ---------------- reset during WRITE ----------------
    task automatic reset_mid_write();
        ecall_seen = 0; mret_seen = 0;
        @(negedge clock);
        bus.in_kind = 2'd0; bus.in_funct3 = 3'd1; bus.in_csr_addr = 12'h341;
        bus.in_rs1_idx = 5'd4; bus.in_rs1_val = 32'hDEAD_BEEF; bus.in_rd = 5'd1;
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        check("wen_before_rst", bus.csr_wen, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("wen_in_rst", bus.csr_wen, 1'b0);
        check("addr_in_rst", bus.csr_addr, 12'h0);
        check("rpc_in_rst", bus.out_redirect_pc, RST_TGT);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("post_rst_valid", bus.out_valid, 1'b0);
            check("post_rst_ready", bus.in_ready, 1'b1);
        end
        check("post_rst_pulses", ecall_seen + mret_seen, 0);
    endtask

    // ---------------- main sequence ----------------
    logic [11:0] addr_tbl [8];

    initial begin
        addr_tbl = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h7C0, 12'h301};
        ref_csr[12'h300] = 32'h0000_1800;
        ref_csr[12'h305] = 32'h0;
        ref_csr[12'h341] = 32'h0;
        ref_csr[12'h342] = 32'h0;
        ref_csr[12'hF11] = 32'h0000_0612;
        ref_csr[12'hF12] = 32'h2306_0124;
        ecall_seen = 0; mret_seen = 0; exp_pc = '0; exp_a5 = '0;

        bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_funct3 = '0; bus.in_csr_addr = '0;
        bus.in_rs1_idx = '0; bus.in_rs1_val = '0; bus.in_rd = '0; bus.in_pc = '0;
        bus.in_a5 = '0; bus.i_mtvec = '0; bus.i_mepc = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_csr_wen", bus.csr_wen, 1'b0);
        check("rst_pulses", {bus.o_ecall, bus.o_mret}, 2'b00);
        check("rst_out_flags", {bus.out_valid, bus.out_rd_wen, bus.out_redirect, bus.out_illegal}, 4'h0);
        check("rst_data", {bus.csr_addr, bus.csr_wdata, bus.o_pc, bus.o_a5, bus.out_rd, bus.out_rd_data}, 113'h0);
        check("rst_redirect_pc", bus.out_redirect_pc, RST_TGT);
        @(negedge clock);
        rst_n = 1'b1;

        run_instr(2'd0, 3'd1, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 0, 0, 0, 0, 0);
        run_instr(2'd0, 3'd2, 12'h300, 5'd3, 32'h0000_0008, 5'd7, 0, 0, 0, 0, 1);
        run_instr(2'd0, 3'd3, 12'h300, 5'd0, 32'h0000_00FF, 5'd2, 0, 0, 0, 0, 0);
        run_instr(2'd1, 3'd0, 12'h000, 5'd0, 0, 5'd0, 32'h8000_0010, 32'hB, 32'h8000_0100, 32'h1234, 2);
        run_instr(2'd2, 3'd0, 12'h000, 5'd0, 0, 5'd0, 32'h4444, 32'h5, 32'h9999, 32'h8000_0010, 0);
        run_instr(2'd0, 3'd1, 12'hF11, 5'd6, 32'h1, 5'd8, 0, 0, 0, 0, 0);
        run_instr(2'd0, 3'd2, 12'h7C0, 5'd2, 32'h1, 5'd8, 0, 0, 0, 0, 0);
        run_instr(2'd0, 3'd2, 12'hF12, 5'd0, 32'h0, 5'd9, 0, 0, 0, 0, 0);
        run_instr(2'd3, 3'd1, 12'h300, 5'd1, 32'h1, 5'd3, 0, 0, 0, 0, 0);
        run_instr(2'd0, 3'd4, 12'h300, 5'd1, 32'h1, 5'd3, 0, 0, 0, 0, 0);
        run_instr(2'd0, 3'd5, 12'h342, 5'd31, 32'h0, 5'd0, 0, 0, 0, 0, 4);
        run_instr(2'd0, 3'd7, 12'h300, 5'd8, 32'h0, 5'd4, 0, 0, 0, 0, 0);

        reset_mid_write();
        run_instr(2'd0, 3'd2, 12'h341, 5'd0, 32'h0, 5'd6, 0, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int r;
            logic [1:0] k;
            logic [4:0] idx;
            r = $urandom_range(0, 99);
            k = (r < 70) ? 2'd0 : (r < 80) ? 2'd1 : (r < 90) ? 2'd2 : 2'd3;
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_instr(k, 3'($urandom_range(0, 7)), addr_tbl[$urandom_range(0, 7)], idx,
                      $urandom, 5'($urandom_range(0, 31)), $urandom, $urandom,
                      $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the machine-mode CSR register-file interface. Sits in the execute stage.
- Accepts one SYSTEM instruction at a time from decode over a valid/ready handshake.
- Sequences the CSR read, the read-modify-write and the ecall/mret trap pulses toward the CSR register file.
- Returns the old CSR value plus any PC redirect to writeback over a second valid/ready handshake.

Parameters:
- XLEN, 32, data width of CSR values, operands and PCs.
- RESET_PC_TGT, 32'h0, reset value of out_redirect_pc.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  unit can accept.
- in_kind  in  2  0=CSR op, 1=ecall, 2=mret, 3=reserved.
- in_funct3  in  3  CSR op: 1=RW, 2=RS, 3=RC, 5=RWI, 6=RSI, 7=RCI.
- in_csr_addr  in  12  CSR address.
- in_rs1_idx  in  5  rs1 index; doubles as zimm for the I forms.
- in_rs1_val  in  XLEN  rs1 register value.
- in_rd  in  5  destination register index.
- in_pc  in  XLEN  instruction PC.
- in_a5  in  XLEN  value of a5; becomes the ecall cause.
- csr_addr  out  12  address to the CSR file.
- csr_wdata  out  XLEN  write data.
- csr_wen  out  1  write strobe.
- csr_rdata  in  XLEN  combinational read data.
- o_ecall  out  1  ecall pulse.
- o_mret  out  1  mret pulse.
- o_pc  out  XLEN  PC sent with ecall.
- o_a5  out  XLEN  cause sent with ecall.
- i_mtvec  in  XLEN  valid only while o_ecall=1.
- i_mepc  in  XLEN  valid only while o_ecall or o_mret=1.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts.
- out_rd  out  5  destination register index.
- out_rd_wen  out  1  write rd.
- out_rd_data  out  XLEN  old CSR value.
- out_redirect  out  1  PC redirect required.
- out_redirect_pc  out  XLEN  redirect target.
- out_illegal  out  1  illegal-instruction flag.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - csr_wen, o_ecall, o_mret, out_valid, out_rd_wen, out_redirect and out_illegal are 0.
  - All data outputs are 0, except out_redirect_pc, which is RESET_PC_TGT.
  - Reset asserted mid-operation abandons the instruction. No write or pulse is issued after release.
- FSM states: IDLE, READ, WRITE, TRAP, RESP.
- IDLE:
  - in_ready=1; in_ready is 0 in every other state.
  - A handshake (in_valid & in_ready) latches all in_* fields.
  - Next state: kind 0 -> READ; kinds 1 and 2 -> TRAP; kind 3 -> RESP with illegal=1.
  - funct3 of 0 or 4 under kind 0 -> RESP with illegal=1.
- READ:
  - Drive csr_addr; register csr_rdata into old_q.
  - Operand src = rs1_val for funct3 1-3, or zero-extended rs1_idx for funct3 5-7.
  - New value: RW -> src; RS -> old_q | src; RC -> old_q & ~src.
  - Next state: WRITE.
- WRITE:
  - csr_addr is held; csr_wen=1 for exactly this one cycle when write_req is set and the address is legal.
  - write_req is always set for RW/RWI, including rd=0.
  - write_req for RS/RC/RSI/RCI is set only when rs1_idx != 0.
  - Legal addresses: 0x300, 0x305, 0x341, 0x342 (writable); 0xF11, 0xF12 (read-only).
  - Any other address -> illegal, no write.
  - write_req to a read-only address -> illegal, no write.
  - Next state: RESP.
- TRAP:
  - One cycle with o_ecall=1 (kind 1) or o_mret=1 (kind 2).
  - During the ecall cycle, o_pc=latched pc and o_a5=latched a5.
  - Target captured the same cycle: ecall -> i_mtvec, mret -> i_mepc. It is stored in out_redirect_pc.
  - Next state: RESP.
- RESP:
  - out_valid=1; every out_* is held stable until out_ready.
  - CSR op: out_rd_wen = legal & (rd != 0); out_rd_data = old_q; out_redirect=0.
  - Trap: out_redirect=1, out_rd_wen=0.
  - Illegal: out_illegal=1, out_rd_wen=0, no CSR write and no pulse.
  - On out_valid & out_ready -> IDLE. No new instruction is accepted in the same cycle.
- Latency, counted from the input handshake at edge N:
  - CSR op: out_valid from cycle N+3.
  - Trap: out_valid from cycle N+2.
  - Immediate illegal: out_valid from cycle N+1.
- Outputs outside their own state: csr_addr=0 and csr_wdata=0; o_pc and o_a5 = 0.
- Throughput: at most one instruction in flight.

Test Plan:
- CSRRW 0x305, rs1_val=0x80000100, rd=5, csr_rdata=0 -> csr_wen=1 for one cycle, csr_wdata=0x80000100; out_rd_data=0, out_rd_wen=1, out_valid at N+3.
- CSRRS 0x300, rs1_idx=3, rs1_val=0x8, old=0x1800 -> csr_wdata=0x1808, out_rd_data=0x1800; CSRRC with rs1_idx=0 -> csr_wen never asserts.
- ecall, pc=0x80000010, a5=0xB, i_mtvec=0x80000100 -> o_ecall high exactly one cycle with o_pc=0x80000010, o_a5=0xB; out_redirect=1, out_redirect_pc=0x80000100; mret with i_mepc=0x80000010 -> o_mret pulse, redirect 0x80000010.
- CSRRW to 0xF11, and CSRRS to 0x7C0 -> out_illegal=1, csr_wen=0, out_rd_wen=0; CSRRS 0xF12 with rs1_idx=0 -> legal, out_rd_data=0x23060124.
- out_ready held low 4 cycles in RESP -> outputs stable and in_ready=0; drop rst_n during WRITE -> csr_wen falls immediately, FSM in IDLE after release, no later pulses.
